// File: rtl/bcd_counter_sseg_if.sv
// Control/status bundle between the stopwatch controller and bcd_counter_sseg.
// seg0..seg3 feed the multiplexed display driver; seg0 is the rightmost digit.
interface bcd_counter_sseg_if;
  // There is no valid/ready pair. start_stop and clr are single-cycle pulses
  // that act on the clk edge where they are high. up is a level sampled on
  // every tick. All outputs are registered and valid in every cycle.
  logic        start_stop;
  logic        clr;
  logic        up;
  logic [15:0] count;
  logic        wrap;
  logic        running;
  logic        state_dbg;
  logic [6:0]  seg0;
  logic [6:0]  seg1;
  logic [6:0]  seg2;
  logic [6:0]  seg3;

  modport master (
    output start_stop, clr, up,
    input  count, wrap, running, state_dbg, seg0, seg1, seg2, seg3
  );

  modport slave (
    input  start_stop, clr, up,
    output count, wrap, running, state_dbg, seg0, seg1, seg2, seg3
  );
endinterface

// File: rtl/bcd_counter_sseg.sv
// Four-digit BCD up/down counter with run/stop FSM, tick prescaler and registered
// active-low 7-segment digits. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_counter_sseg #(
  parameter int TICK_DIV = 100_000_000
) (
  input logic             clk,
  input logic             reset,
  bcd_counter_sseg_if.slave bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic { STOP = 1'b0, RUN = 1'b1 } state_t;

  state_t        state;
  logic          running;
  logic [PW-1:0] pre;
  logic [15:0]   count;
  logic          wrap;
  logic [6:0]    seg0, seg1, seg2, seg3;
  logic          tick;
  logic [16:0]   stepped;

  // Ripple one BCD step through the digits; bit 16 is the carry/borrow out.
  function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic dir);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (dir) begin
          if (v[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  assign tick    = (state == RUN) && (pre == TICK_LAST);
  assign stepped = bcd_step(count, bus.up);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= STOP;
      running <= 1'b0;
      pre     <= '0;
      count   <= 16'h0000;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (bus.start_stop) begin
        state   <= (state == RUN) ? STOP : RUN;
        running <= (state == STOP);
      end
      // clr wins over a coincident tick; the prescaler only moves in RUN.
      if (bus.clr) begin
        count <= 16'h0000;
        pre   <= '0;
      end else if (tick) begin
        pre   <= '0;
        count <= stepped[15:0];
        wrap  <= stepped[16];
      end else if (state == RUN) begin
        pre <= pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg0 <= SEG_ZERO;
`ifdef LEADING_ZERO_BLANK_EN
      seg1 <= SEG_BLANK;
      seg2 <= SEG_BLANK;
      seg3 <= SEG_BLANK;
`else
      seg1 <= SEG_ZERO;
      seg2 <= SEG_ZERO;
      seg3 <= SEG_ZERO;
`endif
    end else begin
      seg0 <= seg_enc(count[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
      seg1 <= (count[15:4]  == 12'd0) ? SEG_BLANK : seg_enc(count[7:4]);
      seg2 <= (count[15:8]  == 8'd0)  ? SEG_BLANK : seg_enc(count[11:8]);
      seg3 <= (count[15:12] == 4'd0)  ? SEG_BLANK : seg_enc(count[15:12]);
`else
      seg1 <= seg_enc(count[7:4]);
      seg2 <= seg_enc(count[11:8]);
      seg3 <= seg_enc(count[15:12]);
`endif
    end
  end

  assign bus.count     = count;
  assign bus.wrap      = wrap;
  assign bus.running   = running;
  assign bus.state_dbg = state;
  assign bus.seg0      = seg0;
  assign bus.seg1      = seg1;
  assign bus.seg2      = seg2;
  assign bus.seg3      = seg3;
endmodule

// File: tb/tb_bcd_counter_sseg.sv
// Bench for bcd_counter_sseg: integer reference model feeds an expected queue,
// a negedge monitor compares every cycle; directed scenarios then random traffic.
module tb_bcd_counter_sseg;
  localparam int TICK_DIV = 4;
  localparam int W = 46;  // {count[16], wrap, running, seg3, seg2, seg1, seg0}
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bcd_counter_sseg_if bus ();

  bcd_counter_sseg #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int  m_cnt = 0;
  int  m_pre = 0;
  bit  m_run = 1'b0;
  bit  m_last_tick = 1'b0;
  logic [W-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [27:0] seg_word(input int v);
    logic [6:0] s [4];
    int p;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      s[i] = SEG_TAB[(v / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < p) s[i] = BLANK;
`endif
      p = p * 10;
    end
    return {s[3], s[2], s[1], s[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs, then after the edge records what the DUT must show.
  task automatic step(input bit ss, input bit c, input bit u);
    int seg_src;
    bit w;
    bus.start_stop = ss;
    bus.clr        = c;
    bus.up         = u;
    @(posedge clk);
    seg_src     = m_cnt;
    w           = 1'b0;
    m_last_tick = m_run && (m_pre == TICK_DIV - 1);
    if (c) begin
      m_cnt = 0;
      m_pre = 0;
    end else if (m_last_tick) begin
      m_pre = 0;
      if (u) begin
        w     = (m_cnt == 9999);
        m_cnt = (m_cnt + 1) % 10000;
      end else begin
        w     = (m_cnt == 0);
        m_cnt = (m_cnt + 9999) % 10000;
      end
    end else if (m_run) begin
      m_pre = m_pre + 1;
    end
    if (ss) m_run = !m_run;
    exp_q.push_back({to_bcd(m_cnt), w, m_run, seg_word(seg_src)});
    #1;
    bus.start_stop = 1'b0;
    bus.clr        = 1'b0;
  endtask

  task automatic run_until_tick(input bit u, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 4 * TICK_DIV && !got; i++) begin
      step(1'b0, 1'b0, u);
      got = m_last_tick;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no tick within %0d cycles", name, 4 * TICK_DIV);
    end
  endtask

  task automatic ticks(input int n, input bit u);
    for (int i = 0; i < n; i++) run_until_tick(u, "tick_wait");
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("areset_count", 32'(bus.count), 32'h0000);
    check("areset_running", 32'(bus.running), 32'h0);
    check("areset_wrap", 32'(bus.wrap), 32'h0);
    check("areset_seg", 32'({bus.seg3, bus.seg2, bus.seg1, bus.seg0}), 32'(seg_word(0)));
    m_cnt = 0;
    m_pre = 0;
    m_run = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", 32'(bus.count), 32'(e[45:30]));
        check("wrap", 32'(bus.wrap), 32'(e[29]));
        check("running", 32'(bus.running), 32'(e[28]));
        check("state_dbg", 32'(bus.state_dbg), 32'(e[28]));
        check("seg", 32'({bus.seg3, bus.seg2, bus.seg1, bus.seg0}), 32'(e[27:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start_stop = 1'b0;
    bus.clr        = 1'b0;
    bus.up         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_count", 32'(bus.count), 32'h0000);
    check("reset_running", 32'(bus.running), 32'h0);
    check("reset_wrap", 32'(bus.wrap), 32'h0);
    check("reset_seg0", 32'(bus.seg0), 32'(7'b1000000));
    check("reset_seg321", 32'({bus.seg3, bus.seg2, bus.seg1}), 32'(seg_word(0) >> 7));
    reset = 1'b0;

    // Idle in STOP.
    repeat (20) step(1'b0, 1'b0, 1'b1);
    check("idle_count", 32'(bus.count), 32'h0000);

    // Start and run 40 cycles upward: ten ticks.
    step(1'b1, 1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b0, 1'b1);
    check("run40_count", 32'(bus.count), 32'h0010);
    check("run40_running", 32'(bus.running), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    check("run40_seg1", 32'(bus.seg1), 32'(7'b1111001));
    check("run40_seg0", 32'(bus.seg0), 32'(7'b1000000));

    // Down from 0000 wraps to 9999.
    step(1'b0, 1'b1, 1'b0);
    run_until_tick(1'b0, "down_wrap");
    check("down_wrap_count", 32'(bus.count), 32'h9999);
    check("down_wrap_pulse", 32'(bus.wrap), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("down_wrap_seg", 32'({bus.seg3, bus.seg2, bus.seg1, bus.seg0}),
          32'({4{7'b0010000}}));
    check("down_wrap_clear", 32'(bus.wrap), 32'h0);

    // 9998 -> 9999 -> 0000 upward.
    run_until_tick(1'b0, "to_9998");
    check("count_9998", 32'(bus.count), 32'h9998);
    run_until_tick(1'b1, "to_9999");
    check("count_9999", 32'(bus.count), 32'h9999);
    check("no_wrap_9999", 32'(bus.wrap), 32'h0);
    run_until_tick(1'b1, "up_wrap");
    check("up_wrap_count", 32'(bus.count), 32'h0000);
    check("up_wrap_pulse", 32'(bus.wrap), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    check("up_wrap_once", 32'(bus.wrap), 32'h0);

    // Prescaler holds across a stop: clr, 1 cycle, stop at prescaler 2.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("paused_running", 32'(bus.running), 32'h0);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("resume_1cyc", 32'(bus.count), 32'h0000);
    step(1'b0, 1'b0, 1'b1);
    check("resume_2cyc", 32'(bus.count), 32'h0001);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("clr_tick_count", 32'(bus.count), 32'h0000);
    check("clr_tick_wrap", 32'(bus.wrap), 32'h0);
    check("clr_tick_running", 32'(bus.running), 32'h1);

    // 0042 and 0100 display patterns.
    ticks(42, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("c42_count", 32'(bus.count), 32'h0042);
    check("c42_seg1", 32'(bus.seg1), 32'(7'b0011001));
    check("c42_seg0", 32'(bus.seg0), 32'(7'b0100100));
`ifdef LEADING_ZERO_BLANK_EN
    check("c42_seg32", 32'({bus.seg3, bus.seg2}), 32'({BLANK, BLANK}));
`else
    check("c42_seg32", 32'({bus.seg3, bus.seg2}), 32'({2{7'b1000000}}));
`endif
    ticks(58, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("c100_count", 32'(bus.count), 32'h0100);
    check("c100_seg2", 32'(bus.seg2), 32'(7'b1111001));
    check("c100_seg1", 32'(bus.seg1), 32'(7'b1000000));

    // Asynchronous reset mid-count; counting must not resume on its own.
    repeat (3) step(1'b0, 1'b0, 1'b1);
    async_reset();
    repeat (12) step(1'b0, 1'b0, 1'b1);
    check("post_reset_count", 32'(bus.count), 32'h0000);

    // Random traffic around zero so both wrap directions occur.
    begin
      bit u;
      u = 1'b0;
      step(1'b1, 1'b0, u);
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) u = ~u;
        step($urandom_range(0, 15) == 0, $urandom_range(0, 47) == 0, u);
      end
    end

    // Drain the expected queue with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected entries left", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
